// File: rtl/fir_chan_sched.sv
// fir_chan_sched: captures one packed multi-lane ADC word per frame and
// issues its enabled lanes, lowest channel first, one per handshake to a
// shared FIR core on a channel-tagged stream port.
module fir_chan_sched #(
  parameter int CHANNELS   = 16,
  parameter int DATA_WIDTH = 16,
  parameter int CH_W       = $clog2(CHANNELS)
) (
  input  logic                           clk,
  input  logic                           nrst,
  input  logic                           s_tvalid,
  output logic                           s_tready,
  input  logic [CHANNELS*DATA_WIDTH-1:0] s_tdata,
  input  logic [CHANNELS-1:0]            ch_mask,
  output logic                           f_tvalid,
  input  logic                           f_tready,
  output logic [DATA_WIDTH-1:0]          f_tdata,
  output logic [CH_W-1:0]                f_tchan,
  output logic                           f_tlast,
  output logic                           busy,
  output logic [15:0]                    frame_cnt
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t                         state, state_nxt;
  logic                           ready_q, ready_nxt;
  logic [CH_W-1:0]                ptr, ptr_nxt;
  logic [CHANNELS*DATA_WIDTH-1:0] buf_q;
  logic [CHANNELS-1:0]            mask_q;
  logic [15:0]                    cnt_q;

  logic                           accept;
  logic [CH_W-1:0]                first_ptr;
  logic [CH_W-1:0]                next_ptr;
  logic                           has_next;
  logic [CHANNELS*DATA_WIDTH-1:0] lane_sel;

  assign accept = (state == IDLE) && s_tvalid && ready_q;

  // Lowest set bit of the incoming mask: first lane of a new frame.
  always_comb begin
    logic [CHANNELS-1:0] m;
    first_ptr = '0;
    m         = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      m = ch_mask >> (i - 1);
      if (m[0]) first_ptr = CH_W'(i - 1);
    end
  end

  // Priority encoder over captured mask bits strictly above the pointer.
  always_comb begin
    logic [CHANNELS-1:0] m;
    next_ptr = '0;
    has_next = 1'b0;
    m        = '0;
    for (int unsigned i = CHANNELS; i > 0; i--) begin
      m = mask_q >> (i - 1);
      if (m[0] && ((i - 1) > 32'(ptr))) begin
        next_ptr = CH_W'(i - 1);
        has_next = 1'b1;
      end
    end
  end

  // Lane select out of the frame buffer.
  always_comb begin
    lane_sel = buf_q >> (32'(ptr) * DATA_WIDTH);
  end

  // Next-state and handshake control.
  always_comb begin
    state_nxt = state;
    ready_nxt = ready_q;
    ptr_nxt   = ptr;
    case (state)
      IDLE: begin
        ready_nxt = 1'b1;
        if (accept && (ch_mask != '0)) begin
          state_nxt = ISSUE;
          ready_nxt = 1'b0;
          ptr_nxt   = first_ptr;
        end
      end
      ISSUE: begin
        ready_nxt = 1'b0;
        if (f_tready) begin
          if (!has_next) begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
          end else begin
            ptr_nxt = next_ptr;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        ready_nxt = 1'b0;
      end
    endcase
  end

  // State, pointer and handshake-ready registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      ptr     <= '0;
    end else begin
      state   <= state_nxt;
      ready_q <= ready_nxt;
      ptr     <= ptr_nxt;
    end
  end

  // Frame capture and accepted-frame counter (zero-mask frames count too).
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      buf_q  <= '0;
      mask_q <= '0;
      cnt_q  <= '0;
    end else if (accept) begin
      buf_q  <= s_tdata;
      mask_q <= ch_mask;
      cnt_q  <= cnt_q + 16'd1;
    end
  end

  assign s_tready  = ready_q;
  assign f_tvalid  = (state == ISSUE);
  assign f_tdata   = (state == ISSUE) ? lane_sel[DATA_WIDTH-1:0] : '0;
  assign f_tchan   = (state == ISSUE) ? ptr : '0;
  assign f_tlast   = (state == ISSUE) && !has_next;
  assign busy      = (state != IDLE);
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_fir_chan_sched.sv
// Self-checking bench for fir_chan_sched: a frame-level reference model
// (queue of pending beats) checked every cycle, plus a vector table and
// hand-written corner-case sequences.
module tb_fir_chan_sched;

  localparam int CH = 16;
  localparam int DW = 16;

  logic           clk = 1'b0;
  logic           nrst = 1'b0;
  logic           s_tvalid = 1'b0;
  logic           s_tready;
  logic [CH*DW-1:0] s_tdata = '0;
  logic [CH-1:0]  ch_mask = '0;
  logic           f_tvalid;
  logic           f_tready = 1'b0;
  logic [DW-1:0]  f_tdata;
  logic [3:0]     f_tchan;
  logic           f_tlast;
  logic           busy;
  logic [15:0]    frame_cnt;

  fir_chan_sched #(.CHANNELS(CH), .DATA_WIDTH(DW), .CH_W(4)) dut (
    .clk(clk), .nrst(nrst),
    .s_tvalid(s_tvalid), .s_tready(s_tready), .s_tdata(s_tdata), .ch_mask(ch_mask),
    .f_tvalid(f_tvalid), .f_tready(f_tready), .f_tdata(f_tdata), .f_tchan(f_tchan),
    .f_tlast(f_tlast), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  chan;
    logic [15:0] data;
    logic        last;
  } beat_t;

  // Reference model: beats still owed for the current frame, expected
  // ready flag and frame count.
  beat_t       q[$];
  logic        m_rdy = 1'b0;
  logic [15:0] m_cnt = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    chk("f_tvalid", 32'(f_tvalid), 32'(q.size() != 0));
    chk("busy", 32'(busy), 32'(q.size() != 0));
    chk("s_tready", 32'(s_tready), 32'(m_rdy));
    chk("frame_cnt", 32'(frame_cnt), 32'(m_cnt));
    if (q.size() != 0) begin
      chk("f_tchan", 32'(f_tchan), 32'(q[0].chan));
      chk("f_tdata", 32'(f_tdata), 32'(q[0].data));
      chk("f_tlast", 32'(f_tlast), 32'(q[0].last));
    end
  endtask

  // One clock: model the edge from current inputs, then check #1 later.
  task automatic step();
    logic acc, hs;
    logic [CH*DW-1:0] d;
    logic [CH-1:0]    m;
    acc = s_tvalid && m_rdy && (q.size() == 0);
    hs  = (q.size() != 0) && f_tready;
    d = s_tdata;
    m = ch_mask;
    @(posedge clk);
    if (hs) void'(q.pop_front());
    if (acc) begin
      m_cnt = m_cnt + 16'd1;
      for (int k = 0; k < CH; k++)
        if (m[k]) q.push_back('{chan: 4'(k), data: d[k*DW +: DW], last: 1'b0});
      if (q.size() != 0) q[q.size()-1].last = 1'b1;
    end
    m_rdy = (q.size() == 0);
    #1;
    check_outputs();
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_s_tready"}, 32'(s_tready), 0);
    chk({tag, "_f_tvalid"}, 32'(f_tvalid), 0);
    chk({tag, "_f_tdata"}, 32'(f_tdata), 0);
    chk({tag, "_f_tchan"}, 32'(f_tchan), 0);
    chk({tag, "_f_tlast"}, 32'(f_tlast), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 0);
  endtask

  // Asynchronous reset in mid-cycle; outputs must clear without a clock.
  task automatic do_reset();
    #2 nrst = 1'b0;
    #1 check_all_zero("rst_async");
    q.delete();
    m_rdy = 1'b0;
    m_cnt = '0;
    repeat (3) @(posedge clk);
    #1 check_all_zero("rst_hold");
    @(negedge clk);
    nrst = 1'b1;
    #1;
  endtask

  task automatic set_ramp(input logic [15:0] base);
    for (int k = 0; k < CH; k++) s_tdata[k*DW +: DW] = base + 16'(k);
  endtask

  typedef struct {
    logic [15:0] mask;
    int          beats;
    int          first;
    int          last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{16'hFFFF, 16, 0, 15};
    vecs[1] = '{16'h8011, 3, 0, 15};
    vecs[2] = '{16'h0001, 1, 0, 0};
    vecs[3] = '{16'h8000, 1, 15, 15};
    vecs[4] = '{16'h0000, 0, -1, -1};
    vecs[5] = '{16'h00F0, 4, 4, 7};
    vecs[6] = '{16'h5555, 8, 0, 14};

    // Reset then idle.
    do_reset();
    step();
    chk("ready_after_release", 32'(s_tready), 1);
    step();
    chk("idle_no_valid", 32'(f_tvalid), 0);

    // Vector table, no backpressure.
    f_tready = 1'b1;
    for (int v = 0; v < 7; v++) begin
      int nb, fc, lc, cyc;
      set_ramp(16'h1000);
      ch_mask  = vecs[v].mask;
      s_tvalid = 1'b1;
      step();
      s_tvalid = 1'b0;
      ch_mask  = ~vecs[v].mask;
      set_ramp(16'h7700);
      nb = 0; fc = -1; lc = -1; cyc = 1;
      while (f_tvalid && cyc < 40) begin
        if (fc < 0) fc = f_tchan;
        if (f_tlast) lc = f_tchan;
        nb++;
        step();
        cyc++;
      end
      chk("vec_beats", 32'(nb), 32'(vecs[v].beats));
      chk("vec_first", 32'(fc), 32'(vecs[v].first));
      chk("vec_last", 32'(lc), 32'(vecs[v].last));
      chk("vec_ready_cycles", 32'(cyc), 32'(vecs[v].beats + 1));
      chk("vec_ready", 32'(s_tready), 1);
    end
    chk("vec_frame_cnt", 32'(frame_cnt), 7);

    // Backpressure: chan 0 held for 5 stalled cycles.
    set_ramp(16'h2000);
    ch_mask  = 16'h0003;
    s_tvalid = 1'b1;
    f_tready = 1'b0;
    step();
    s_tvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_hold_chan", 32'(f_tchan), 0);
      chk("bp_hold_data", 32'(f_tdata), 32'h2000);
      chk("bp_hold_valid", 32'(f_tvalid), 1);
      step();
    end
    f_tready = 1'b1;
    step();
    chk("bp_chan1", 32'(f_tchan), 1);
    chk("bp_last1", 32'(f_tlast), 1);
    step();
    chk("bp_done", 32'(f_tvalid), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      s_tvalid = ($urandom_range(0, 3) != 0);
      f_tready = ($urandom_range(0, 9) < 7);
      ch_mask  = ($urandom_range(0, 7) == 0) ? 16'h0000 : 16'($urandom);
      for (int k = 0; k < CH; k++) s_tdata[k*DW +: DW] = 16'($urandom);
      step();
    end
    s_tvalid = 1'b0;
    f_tready = 1'b1;
    repeat (20) step();

    // Reset mid-frame after the 5th beat, then a fresh frame.
    set_ramp(16'h3000);
    ch_mask  = 16'hFFFF;
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    repeat (5) step();
    chk("mid_chan5", 32'(f_tchan), 5);
    do_reset();
    step();
    set_ramp(16'h4400);
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    chk("post_rst_chan", 32'(f_tchan), 0);
    chk("post_rst_data", 32'(f_tdata), 32'h4400);
    chk("post_rst_cnt", 32'(frame_cnt), 1);
    repeat (17) step();

    // Zero mask and counter wrap.
    do_reset();
    step();
    ch_mask  = '0;
    s_tvalid = 1'b1;
    repeat (65535) step();
    chk("wrap_pre", 32'(frame_cnt), 32'hFFFF);
    step();
    chk("wrap_zero", 32'(frame_cnt), 0);
    chk("wrap_ready", 32'(s_tready), 1);
    chk("wrap_valid", 32'(f_tvalid), 0);
    s_tvalid = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fir_chan_sched.md
# fir_chan_sched

Channel scheduler that time-multiplexes a single shared FIR core across the CHANNELS lanes of the packed ADC input word. Each accepted input word is captured into a frame buffer. The enabled lanes are then issued one per handshake, in ascending channel order, on a channel-tagged AXI-Stream-style port. The block sits between the multi-lane sample source and the FIR datapath, replacing the hard-wired "lane 0 only" selection.

## Interface
- CHANNELS, 16, number of packed input lanes
- DATA_WIDTH, 16, bits per lane (Q1.15 signed)
- CH_W, $clog2(CHANNELS), width of channel tag
- clk  in  1  single clock, all logic on rising edge
- nrst  in  1  reset, asynchronous, active-low
- s_tvalid  in  1  input frame valid
- s_tready  out  1  frame buffer free; registered
- s_tdata  in  CHANNELS*DATA_WIDTH  packed lanes, lane k at [k*DATA_WIDTH +: DATA_WIDTH]
- ch_mask  in  CHANNELS  per-lane enable, sampled with s_tdata on accept
- f_tvalid  out  1  sample to FIR valid
- f_tready  in  1  FIR accepts sample
- f_tdata  out  DATA_WIDTH  selected lane sample, signed
- f_tchan  out  CH_W  channel index of f_tdata
- f_tlast  out  1  last enabled lane of current frame
- busy  out  1  frame in progress (state != IDLE)
- frame_cnt  out  16  count of accepted input frames, wraps

## Operation
- States: IDLE, ISSUE.
- IDLE: s_tready=1, f_tvalid=0. On s_tvalid && s_tready:
  - capture s_tdata into frame buffer and ch_mask into mask register;
  - frame_cnt += 1.
- If the captured mask is nonzero: s_tready<=0; load channel pointer with the lowest set mask bit; go to ISSUE.
- If the captured mask is zero: stay IDLE, s_tready stays 1, no beats are issued. The frame still counts.
- ISSUE: f_tvalid=1, f_tdata=buffer[ptr], f_tchan=ptr. f_tlast=1 iff no set mask bit above ptr.
- On f_tvalid && f_tready:
  - if f_tlast: go to IDLE and set s_tready<=1;
  - otherwise: ptr <= next higher set mask bit. Masked lanes are skipped with zero bubble cycles.
- While f_tvalid && !f_tready: f_tdata, f_tchan and f_tlast are held stable. f_tvalid is never withdrawn before the handshake.
- ch_mask and s_tdata changes after capture have no effect on the frame in flight.
- frame_cnt wraps from 0xFFFF to 0x0000.
- Next-set-bit search is a combinational priority encoder over mask bits above ptr.

## Timing
- Reset (nrst low, asynchronous), all outputs:
  - state=IDLE, s_tready=0, f_tvalid=0, f_tdata=0, f_tchan=0, f_tlast=0, busy=0, frame_cnt=0;
  - buffer and mask cleared.
- s_tready rises on the first clk edge after nrst deasserts.
- Latency: input accepted at edge N gives f_tvalid=1 in the cycle after edge N, i.e. the first beat is visible from N+1.
- With f_tready=1 and M enabled lanes: M beats on consecutive cycles. s_tready is high again after the edge that completes the last beat.
- Full-rate throughput (all 16 lanes enabled): one frame per 17 cycles.
- No overlap: a new frame is accepted only in IDLE. The last-beat handshake and the new accept never occur on the same edge.
- Reset asserted mid-frame: the in-flight frame is abandoned and all outputs take their reset values immediately. No partial f_tlast is issued after release.

## Test plan
- Reset then idle: hold nrst low 3 cycles, release.
  - All outputs 0 during reset; s_tready=1 one edge after release; f_tvalid stays 0.
- Full frame, no backpressure: lane k = 0x1000+k, ch_mask=0xFFFF, f_tready=1.
  - 16 consecutive beats, f_tchan 0..15, f_tdata 0x1000..0x100F;
  - f_tlast only on chan 15; s_tready back high after 17 cycles; frame_cnt=1.
- Sparse mask: ch_mask=0x8011.
  - Exactly 3 beats, chan 0, 4, 15, back-to-back; f_tlast on chan 15.
- Backpressure: ch_mask=0x0003, f_tready low for 5 cycles, then high.
  - chan 0 beat held stable 5 cycles; then chan 0 and chan 1 accepted on successive edges.
- Zero mask and wrap: preload frame_cnt to 0xFFFF via 65535 accepts with ch_mask=0, then one more accept.
  - No f_tvalid ever; s_tready continuously 1; frame_cnt=0x0000.
- Reset mid-frame: ch_mask=0xFFFF, assert nrst after the 5th beat.
  - Outputs zero asynchronously; after release the next frame starts at chan 0 with a fresh capture.
